// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and helpers for the register-file access controller
package regfile_ctrl_pkg;

  // Operand size codes; 2'b11 is handled as a long access
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_WORD = 2'b01,
    SIZE_LONG = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ISSUE  = 3'd1,
    ST_RD_DONE   = 3'd2,
    ST_RMW_ISSUE = 3'd3,
    ST_RMW_MERGE = 3'd4,
    ST_WR        = 3'd5
  } state_e;

  // Index bit that selects the address-register bank (A0-A7)
  localparam int AN_BANK_BIT = 3;

  // Both 2'b10 and 2'b11 count as full 32-bit accesses
  function automatic logic is_long(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_addr_reg(input logic [3:0] idx);
    return idx[AN_BANK_BIT];
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - requester and register-file signal bundle
interface regfile_access_ctrl_if #(
  parameter int RF_INDEX_WIDTH = 32
);
  logic                      rd_req;
  logic [3:0]                rd_index;
  logic                      rd_ack;
  logic [31:0]               rd_data;
  logic                      wr_req;
  logic [3:0]                wr_index;
  logic [1:0]                wr_size;
  logic [31:0]               wr_data;
  logic                      wr_ack;
  logic                      busy;
  logic [RF_INDEX_WIDTH-1:0] rf_index;
  logic                      rf_write_enable;
  logic [31:0]               rf_data_in;
  logic [31:0]               rf_data_out;

  // Requesters plus the register file instance
  modport master (
    output rd_req, rd_index, wr_req, wr_index, wr_size, wr_data, rf_data_out,
    input  rd_ack, rd_data, wr_ack, busy, rf_index, rf_write_enable, rf_data_in
  );

  // The access controller
  modport slave (
    input  rd_req, rd_index, wr_req, wr_index, wr_size, wr_data, rf_data_out,
    output rd_ack, rd_data, wr_ack, busy, rf_index, rf_write_enable, rf_data_in
  );
endinterface

// File: rtl/regfile_merge.sv
// rtl/regfile_merge.sv - byte/word merge into Dn and sign extension into An
module regfile_merge
  import regfile_ctrl_pkg::*;
(
  input  logic [31:0] old,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_addr,
  output logic [31:0] result
);

  // Long writes pass through; An sizes sign-extend; Dn sizes keep the old upper bits
  always_comb begin
    result = data;
    if (!is_long(size)) begin
      if (is_addr) begin
        result = (size == SIZE_BYTE) ? {{24{data[7]}}, data[7:0]}
                                     : {{16{data[15]}}, data[15:0]};
      end else begin
        result = (size == SIZE_BYTE) ? {old[31:8], data[7:0]}
                                     : {old[31:16], data[15:0]};
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - arbitrates and sequences all register-file accesses
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter bit ALTERNATE      = 1'b1,
  parameter int RF_INDEX_WIDTH = 32
) (
  input  logic                  raw_clk,
  input  logic                  reset_n,
  regfile_access_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [3:0]  rf_idx_q, rf_idx_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] data_q, data_d;
  logic        last_wr_q, last_wr_d;
  logic        rd_ack_q, rd_ack_d;
  logic        wr_ack_q, wr_ack_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic [31:0] rf_data_in_q, rf_data_in_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        grant_wr;
  logic        grant_rd;
  logic [31:0] merge_data;
  logic [1:0]  merge_size;
  logic        merge_is_addr;
  logic [31:0] merge_result;

  // In IDLE the merge unit serves the direct-write path from live inputs;
  // in RMW_MERGE it works on the latched request and the old register value.
  always_comb begin
    if (state_q == ST_IDLE) begin
      merge_data    = bus.wr_data;
      merge_size    = bus.wr_size;
      merge_is_addr = is_addr_reg(bus.wr_index);
    end else begin
      merge_data    = data_q;
      merge_size    = size_q;
      merge_is_addr = is_addr_reg(rf_idx_q);
    end
  end

  regfile_merge u_merge (
    .old     (bus.rf_data_out),
    .data    (merge_data),
    .size    (merge_size),
    .is_addr (merge_is_addr),
    .result  (merge_result)
  );

  // Arbitration: a lone request wins; contention alternates or favours the write
  always_comb begin
    if (bus.rd_req && bus.wr_req) begin
      grant_wr = ALTERNATE ? !last_wr_q : 1'b1;
    end else begin
      grant_wr = bus.wr_req;
    end
    grant_rd = bus.rd_req && !grant_wr;
  end

  // Next-state and next-output computation; every output is registered
  always_comb begin
    state_d      = state_q;
    rf_idx_d     = rf_idx_q;
    size_d       = size_q;
    data_d       = data_q;
    last_wr_d    = last_wr_q;
    rd_ack_d     = 1'b0;
    wr_ack_d     = 1'b0;
    we_d         = 1'b0;
    rf_data_in_d = rf_data_in_q;
    rd_data_d    = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          rf_idx_d  = bus.wr_index;
          size_d    = bus.wr_size;
          data_d    = bus.wr_data;
          last_wr_d = 1'b1;
          if (is_addr_reg(bus.wr_index) || is_long(bus.wr_size)) begin
            rf_data_in_d = merge_result;
            we_d         = 1'b1;
            wr_ack_d     = 1'b1;
            state_d      = ST_WR;
          end else begin
            state_d = ST_RMW_ISSUE;
          end
        end else if (grant_rd) begin
          rf_idx_d  = bus.rd_index;
          last_wr_d = 1'b0;
          state_d   = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        rd_ack_d = 1'b1;
        state_d  = ST_RD_DONE;
      end
      ST_RD_DONE: begin
        rd_data_d = bus.rf_data_out;
        state_d   = ST_IDLE;
      end
      ST_RMW_ISSUE: begin
        state_d = ST_RMW_MERGE;
      end
      ST_RMW_MERGE: begin
        rf_data_in_d = merge_result;
        we_d         = 1'b1;
        wr_ack_d     = 1'b1;
        state_d      = ST_WR;
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rf_idx_q     <= 4'd0;
      size_q       <= 2'd0;
      data_q       <= 32'd0;
      last_wr_q    <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      rf_data_in_q <= 32'd0;
      rd_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      rf_idx_q     <= rf_idx_d;
      size_q       <= size_d;
      data_q       <= data_d;
      last_wr_q    <= last_wr_d;
      rd_ack_q     <= rd_ack_d;
      wr_ack_q     <= wr_ack_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      rf_data_in_q <= rf_data_in_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // The register file answers during RD_DONE, so the ack cycle shows its data
  // directly and the held copy covers every later cycle.
  assign bus.rd_data         = rd_ack_q ? bus.rf_data_out : rd_data_q;
  assign bus.rd_ack          = rd_ack_q;
  assign bus.wr_ack          = wr_ack_q;
  assign bus.busy            = busy_q;
  assign bus.rf_index        = RF_INDEX_WIDTH'(rf_idx_q);
  assign bus.rf_write_enable = we_q;
  assign bus.rf_data_in      = rf_data_in_q;

endmodule
